// File: rtl/game_master_pkg.sv
// Shared game-phase definitions for the sequencer, renderer and game logic.
package game_master_pkg;

    localparam int unsigned GM_STATE_W = 3;

    // Phase codes decoded by downstream blocks; 6 and 7 are never produced.
    typedef enum logic [GM_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_WON   = 3'd2,
        ST_OVER  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_LCLR  = 3'd5
    } gm_state_e;

    function automatic int unsigned gm_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_master_fsm_edge_rise.sv
// W-bit rising-edge detector: rise_o is combinational on the current input
// against the registered previous sample, so a rise is acted on at the same
// clock edge that first samples the input high.
module edge_rise #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;

    // History updates every cycle; rises in ignoring states are simply lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= '0;
        else         prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/game_master_fsm.sv
// Top-level game sequencer: phase FSM, lives/level counters, phase timer and
// the score-clear / life-lost strobes towards the game logic.
module game_master_fsm
    import game_master_pkg::*;
#(
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned WIN_SCORE      = 10,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned LEVELS         = 4,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned ATTRACT_CYCLES = 500_000_000,
    localparam int unsigned LIV_W = $clog2(LIVES + 1),
    localparam int unsigned LVL_W = $clog2(LEVELS) | 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BTNU,
    input  logic               BTND,
    input  logic               BTNL,
    input  logic               BTNR,
    input  logic [SCORE_W-1:0] Current_score,
    input  logic               Game_over,
    output logic [2:0]         Master_state,
    output logic [LIV_W-1:0]   Lives,
    output logic [LVL_W-1:0]   Level,
    output logic               Score_clr,
    output logic               Life_lost
);

    localparam int unsigned TMR_MAX = gm_max(HOLD_CYCLES, ATTRACT_CYCLES);
    localparam int unsigned TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;

    gm_state_e          state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LIV_W-1:0]   lives_q, lives_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               sclr_q, sclr_d;
    logic               llost_q, llost_d;

    logic [3:0]         rise;
    logic               rise_u, rise_d, rise_l, rise_go;
    logic               score_win, last_level, hold_done, attract_done;

    // BTNR is reserved and deliberately has no effect.
    logic               unused_btnr;
    assign unused_btnr = BTNR;

    edge_rise #(.W(4)) u_edge (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .d_i    ({BTNU, BTND, BTNL, Game_over}),
        .rise_o (rise)
    );

    assign rise_u  = rise[3];
    assign rise_d  = rise[2];
    assign rise_l  = rise[1];
    assign rise_go = rise[0];

    assign score_win    = (32'(Current_score) >= WIN_SCORE);
    assign last_level   = (level_q == LVL_W'(LEVELS - 1));
    assign hold_done    = (timer_q == TMR_W'(HOLD_CYCLES - 1));
    assign attract_done = (timer_q == TMR_W'(ATTRACT_CYCLES - 1));

    // All state, counters and strobes are registered together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            lives_q <= '0;
            level_q <= '0;
            sclr_q  <= 1'b0;
            llost_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lives_q <= lives_d;
            level_q <= level_d;
            sclr_q  <= sclr_d;
            llost_q <= llost_d;
        end
    end

    // Next-state, counter and strobe decode; priorities follow the case order.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lives_d = lives_q;
        level_d = level_q;
        sclr_d  = 1'b0;
        llost_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_u) begin
                    state_d = ST_PLAY;
                    lives_d = LIV_W'(LIVES);
                    level_d = '0;
                    sclr_d  = 1'b1;
                end
            end

            ST_PLAY: begin
                if (rise_d) begin
                    state_d = ST_IDLE;
                end else if (score_win) begin
                    // A win masks a simultaneous life loss.
                    state_d = last_level ? ST_WON : ST_LCLR;
                end else if (rise_go) begin
                    if (lives_q == LIV_W'(1)) begin
                        state_d = ST_OVER;
                        lives_d = '0;
                    end else begin
                        lives_d = lives_q - LIV_W'(1);
                        llost_d = 1'b1;
                    end
                end else if (rise_l) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (rise_d)               state_d = ST_IDLE;
                else if (rise_l || rise_u) state_d = ST_PLAY;
            end

            ST_LCLR: begin
                if (rise_d) begin
                    state_d = ST_IDLE;
                end else if (rise_u || hold_done) begin
                    state_d = ST_PLAY;
                    level_d = level_q + LVL_W'(1);
                    sclr_d  = 1'b1;
                end else if (timer_q != {TMR_W{1'b1}}) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_WON, ST_OVER: begin
                if (rise_u) begin
                    state_d = ST_PLAY;
                    lives_d = LIV_W'(LIVES);
                    level_d = '0;
                    sclr_d  = 1'b1;
                end else if (rise_d || attract_done) begin
                    state_d = ST_IDLE;
                end else if (timer_q != {TMR_W{1'b1}}) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every phase starts its timer from zero.
        if (state_d != state_q) timer_d = '0;
    end

    assign Master_state = state_q;
    assign Lives        = lives_q;
    assign Level        = level_q;
    assign Score_clr    = sclr_q;
    assign Life_lost    = llost_q;

endmodule
